// File: rtl/pending_encoder_8_3_pkg.sv
// -----------------------------------------------------------------------------
// enc_pkg
// Shared definitions for pending_encoder_8_3.
//   N_DEF / W_DEF : default line count and index width
//   N_MAX         : widest supported request line (onehot() result width)
//   enc_state_t   : IDLE (nothing presented) / PRESENT (index on Out)
//   onehot()      : index -> N_MAX-bit one-hot mask; callers truncate to N
// Optional build macro used by the block: ROUND_ROBIN_EN.
// -----------------------------------------------------------------------------
package enc_pkg;

   localparam int N_DEF = 8;
   localparam int W_DEF = 3;
   localparam int N_MAX = 64;

   typedef enum logic {
      IDLE    = 1'b0,
      PRESENT = 1'b1
   } enc_state_t;

   function automatic logic [N_MAX-1:0] onehot(input logic [5:0] idx);
      logic [N_MAX-1:0] m;
      m = {{(N_MAX-1){1'b0}}, 1'b1};
      return m << idx;
   endfunction

endpackage

// File: rtl/pending_encoder_8_3_if.sv
// -----------------------------------------------------------------------------
// pending_encoder_8_3_if
// Request capture and index handshake bundle for pending_encoder_8_3.
//   E         : capture enable (master -> slave)
//   In        : N request pulses (master -> slave)
//   Out       : W-bit presented index (slave -> master)
//   out_valid : Out holds a valid index (slave -> master)
//   out_ready : consumer accepts Out this cycle (master -> slave)
//   pending   : registered pending vector (slave -> master)
//   coalesced : one-cycle pulse, a request hit an already-pending line
// Handshake: a transfer happens on a rising edge where out_valid and
// out_ready are both 1; while out_valid=1 and out_ready=0, Out is held.
// Optional build macro used by the block: ROUND_ROBIN_EN (no effect here).
// -----------------------------------------------------------------------------
interface pending_encoder_8_3_if #(
   parameter int N = 8,
   parameter int W = $clog2(N)
);
   logic         E;
   logic [N-1:0] In;
   logic [W-1:0] Out;
   logic         out_valid;
   logic         out_ready;
   logic [N-1:0] pending;
   logic         coalesced;

   modport master (
      output E, In, out_ready,
      input  Out, out_valid, pending, coalesced
   );

   modport slave (
      input  E, In, out_ready,
      output Out, out_valid, pending, coalesced
   );
endinterface

// File: rtl/pending_encoder_8_3_prio_pick.sv
// -----------------------------------------------------------------------------
// prio_pick
// Combinational priority picker.
//   vec  : candidate lines
//   base : last accepted index (only meaningful with ROUND_ROBIN_EN)
//   idx  : selected line (0 when none)
//   any  : vec has at least one set bit
// ROUND_ROBIN_EN undefined: highest set index wins.
// ROUND_ROBIN_EN defined  : search downward from base-1, wrapping from 0 to
//                           N-1; base itself has lowest priority.
// -----------------------------------------------------------------------------
module prio_pick #(
   parameter int N = 8,
   parameter int W = $clog2(N)
) (
   input  logic [N-1:0] vec,
   input  logic [W-1:0] base,
   output logic [W-1:0] idx,
   output logic         any
);

`ifdef ROUND_ROBIN_EN
   // Walk from lowest priority (base itself, k=N) to highest (base-1, k=1);
   // the last hit overwrites earlier ones. Index math wraps modulo N.
   always_comb begin
      logic [W-1:0] j;
      j   = '0;
      idx = '0;
      any = 1'b0;
      for (int k = N; k >= 1; k--) begin
         j = base - W'(k);
         if (vec[j]) begin
            idx = j;
            any = 1'b1;
         end
      end
   end
`else
   logic w_unused_base;
   assign w_unused_base = ^base;

   // Ascending scan, last hit wins -> highest set index.
   always_comb begin
      idx = '0;
      any = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (vec[i]) begin
            idx = W'(i);
            any = 1'b1;
         end
      end
   end
`endif

endmodule

// File: rtl/pending_encoder_8_3.sv
// -----------------------------------------------------------------------------
// pending_encoder_8_3
// Captures request pulses into a pending register and presents one pending
// line at a time as a binary index over a valid/ready handshake, clearing
// each line as it is accepted.
//   clk         : rising-edge clock
//   rst         : synchronous active-high reset
//   bus (slave) : E, In, Out, out_valid, out_ready, pending, coalesced
//   o_dbg_state : current FSM state
// Build macro ROUND_ROBIN_EN: rotating priority around the last accepted
// index (adds a last_idx register); undefined gives fixed highest-index
// priority.
// All outputs come straight from registers.
// -----------------------------------------------------------------------------
module pending_encoder_8_3
   import enc_pkg::*;
#(
   parameter int N = N_DEF,
   parameter int W = $clog2(N)
) (
   input  logic                  clk,
   input  logic                  rst,
   pending_encoder_8_3_if.slave  bus,
   output enc_state_t            o_dbg_state
);

   enc_state_t   r_state;
   enc_state_t   w_state_nxt;
   logic [N-1:0] r_pending;
   logic [W-1:0] r_out;
   logic         r_coal;

   logic         w_accept;
   logic [N-1:0] w_set;
   logic [N-1:0] w_clr;
   logic [N-1:0] w_cand;
   logic [W-1:0] w_base;
   logic [W-1:0] w_pick_idx;
   logic         w_pick_any;
   logic         w_load;
   logic [W-1:0] w_out_nxt;

   assign w_accept = (r_state == PRESENT) && bus.out_ready;
   assign w_set    = bus.E ? bus.In : '0;
   assign w_clr    = w_accept ? N'(onehot(6'(r_out))) : '0;
   // Candidate excludes this cycle's new sets; in IDLE w_clr is 0 so this
   // is just the pending vector.
   assign w_cand   = r_pending & ~w_clr;

`ifdef ROUND_ROBIN_EN
   logic [W-1:0] r_last_idx;

   always_ff @(posedge clk) begin
      if (rst)           r_last_idx <= '0;
      else if (w_accept) r_last_idx <= r_out;
   end

   // The index being accepted this cycle is already the "last" one for the
   // pick that replaces it.
   assign w_base = w_accept ? r_out : r_last_idx;
`else
   assign w_base = '0;
`endif

   prio_pick #(.N(N), .W(W)) u_pick (
      .vec  (w_cand),
      .base (w_base),
      .idx  (w_pick_idx),
      .any  (w_pick_any)
   );

   // State register plus registered datapath.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= IDLE;
         r_pending <= '0;
         r_out     <= '0;
         r_coal    <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         // Set wins over clear on the same line.
         r_pending <= w_cand | w_set;
         r_coal    <= |(w_set & w_cand);
         if (w_load) r_out <= w_out_nxt;
      end
   end

   // Next-state logic.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (w_pick_any) w_state_nxt = PRESENT;
         PRESENT: if (bus.out_ready && !w_pick_any) w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   // Output logic: when to load a fresh index into Out. With out_ready=0 in
   // PRESENT nothing loads, so a higher-priority arrival cannot preempt.
   always_comb begin
      w_load    = 1'b0;
      w_out_nxt = w_pick_idx;
      case (r_state)
         IDLE:    w_load = w_pick_any;
         PRESENT: w_load = bus.out_ready && w_pick_any;
         default: w_load = 1'b0;
      endcase
   end

   assign bus.Out       = r_out;
   assign bus.out_valid = (r_state == PRESENT);
   assign bus.pending   = r_pending;
   assign bus.coalesced = r_coal;
   assign o_dbg_state   = r_state;

endmodule
